stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Multi-cycle control FSM for the 8-bit nRisc core. It steps one instruction at a time through the seven datapath stages PC, IM, MX, CT, RT, AL and ME. Each stage gets a one-cycle start strobe, and the sequencer waits for that stage's done handshake before moving on. It also provides run/step/halt control, a retired-instruction counter and a per-stage watchdog, so the free-running signal chain between stage modules becomes a controlled, observable sequence.

Parameters:
TIMEOUT, 16, max cycles to wait for a stage done before error (minimum 2)
LOAD_OP, 3'b110, opcode requiring ME stage (load)
STORE_OP, 3'b111, opcode requiring ME stage (store)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; when high, instructions execute back-to-back
step  input  1  one-cycle pulse; in IDLE, execute exactly one instruction
halt_req  input  1  level; stop at next instruction boundary
operation  input  3  opcode from decode, valid once MX done has been seen
stage_done  input  7  done handshake per stage; bit0=PC, 1=IM, 2=MX, 3=CT, 4=RT, 5=AL, 6=ME
stage_start  output  7  one-cycle start strobe per stage, same bit order
busy  output  1  high in any state other than IDLE and ERROR
timeout_err  output  1  sticky; stage done missing within TIMEOUT cycles
err_stage  output  3  index of the stage that timed out
retired  output  8  count of completed instructions, wraps 255->0

Behaviour:
- Reset (sync, active-high, takes priority over everything): state=IDLE; stage_start=0; busy=0; timeout_err=0; err_stage=0; retired=0; watchdog=0; latched opcode=0. Reset mid-instruction abandons the instruction immediately, and no strobe is issued on the cycle after reset.
- States: IDLE, S_PC, S_IM, S_MX, S_CT, S_RT, S_AL, S_ME, ERROR.
- IDLE -> S_PC when (run & ~halt_req) | step. step wins even if halt_req=1. The IDLE exit condition is sampled every cycle.
- Entering any stage state: stage_start[i] is high for exactly the first cycle in that state; all other bits are 0. At most one bit of stage_start is ever high.
- done acceptance: stage_done[i] is sampled only from the cycle after the strobe onward. done on the strobe cycle is ignored. done bits of non-current stages are ignored.
- On an accepted done, advance on the next edge: PC->IM->MX->CT->RT->AL. Minimum latency is 2 cycles per stage.
- S_MX done: latch operation into an internal opcode register. This latched value, not the live input, decides whether ME runs.
- S_AL done: go to S_ME if the latched opcode is LOAD_OP or STORE_OP; otherwise the instruction completes.
- S_ME done: the instruction completes.
- Instruction completion (boundary):
  - retired increments by 1, mod 256.
  - Next state is S_PC if run & ~halt_req and this instruction was not started by step; otherwise IDLE.
  - A step-initiated instruction always returns to IDLE.
- Watchdog: counts cycles in the current stage state and clears on every state change. If the count reaches TIMEOUT without an accepted done, go to ERROR, set timeout_err=1 and err_stage=current stage index.
- ERROR: no strobes, busy=0, retired frozen, run/step ignored. Exit only by reset.
- halt_req mid-instruction has no effect until the boundary. The instruction always finishes.
- Simultaneous done and watchdog expiry on the same cycle: done wins.
- busy=1 from the cycle of the S_PC strobe through the last cycle of the final stage.

Decomposition:
- Shared package nrisc_pkg holds:
  - stage index constants ST_PC=0 … ST_ME=6
  - state encoding localparams
  - opcode constants LOAD_OP and STORE_OP, shared with the controller
- One sub-module, stage_watchdog: a counter with clear, enable and expiry output, parameterised by TIMEOUT. It is reusable by other handshake waiters.
- The FSM, strobe generation and retired counter stay in stage_sequencer.

Test Plan:
1. Single step, ALU op: reset, then step pulse, operation=3'b001, each done returned 1 cycle after its strobe. Expect strobes on bits 0..5 in order, 2 cycles apart, no ME strobe, retired=1, back in IDLE, busy=0 after 12 cycles.
2. Load op: run=1 with operation=LOAD_OP latched at MX done. Expect ME strobe after AL done, retired increments only after ME done, then an immediate PC strobe for the next instruction.
3. Halt at boundary: run=1, assert halt_req during S_RT. Expect RT, AL (and ME if needed) to complete, retired +1, then IDLE with no further PC strobe. Deassert halt_req and execution resumes.
4. Timeout: withhold CT done. Expect ERROR after TIMEOUT=16 cycles in S_CT, with timeout_err=1, err_stage=3, busy=0, and no strobes despite run=1. Reset clears all of it.
5. Early done and reset: assert stage_done[0] on the PC strobe cycle only. Expect the sequencer to stay in S_PC. Then assert reset during S_AL. Expect all outputs at reset values next cycle and retired=0.
6. Wrap: run 256 back-to-back non-memory instructions. Expect retired to return to 0 and the strobe sequence to continue unbroken.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc multi-cycle controller: stage indices,
// sequencer state encoding and the memory opcodes that need the ME stage.
package nrisc_pkg;

    localparam int NUM_STAGES = 7;

    localparam logic [2:0] ST_PC = 3'd0;
    localparam logic [2:0] ST_IM = 3'd1;
    localparam logic [2:0] ST_MX = 3'd2;
    localparam logic [2:0] ST_CT = 3'd3;
    localparam logic [2:0] ST_RT = 3'd4;
    localparam logic [2:0] ST_AL = 3'd5;
    localparam logic [2:0] ST_ME = 3'd6;

    localparam logic [3:0] ENC_IDLE  = 4'd0;
    localparam logic [3:0] ENC_PC    = 4'd1;
    localparam logic [3:0] ENC_IM    = 4'd2;
    localparam logic [3:0] ENC_MX    = 4'd3;
    localparam logic [3:0] ENC_CT    = 4'd4;
    localparam logic [3:0] ENC_RT    = 4'd5;
    localparam logic [3:0] ENC_AL    = 4'd6;
    localparam logic [3:0] ENC_ME    = 4'd7;
    localparam logic [3:0] ENC_ERROR = 4'd8;

    localparam logic [2:0] LOAD_OP  = 3'b110;
    localparam logic [2:0] STORE_OP = 3'b111;

    typedef enum logic [3:0] {
        IDLE  = ENC_IDLE,
        S_PC  = ENC_PC,
        S_IM  = ENC_IM,
        S_MX  = ENC_MX,
        S_CT  = ENC_CT,
        S_RT  = ENC_RT,
        S_AL  = ENC_AL,
        S_ME  = ENC_ME,
        ERROR = ENC_ERROR
    } seq_state_t;

    // True for the seven states that own a datapath stage.
    function automatic logic is_stage_state(input seq_state_t s);
        return (s != IDLE) && (s != ERROR);
    endfunction

    // Stage index owned by a stage state (0 for IDLE/ERROR, never used there).
    function automatic logic [2:0] stage_of(input seq_state_t s);
        logic [2:0] idx;
        idx = '0;
        case (s)
            S_PC:    idx = ST_PC;
            S_IM:    idx = ST_IM;
            S_MX:    idx = ST_MX;
            S_CT:    idx = ST_CT;
            S_RT:    idx = ST_RT;
            S_AL:    idx = ST_AL;
            S_ME:    idx = ST_ME;
            default: idx = '0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Cycle counter for a handshake waiter: cleared on each new wait, counts
// while enabled and flags expiry on the TIMEOUT-th enabled cycle.
module stage_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count enabled cycles since the last clear, holding at the expiry value.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle controller for the 8-bit nRisc core: strobes each datapath
// stage in turn, waits for its done handshake, counts retired instructions
// and traps into ERROR when a stage never answers.
module stage_sequencer #(
    parameter int         TIMEOUT  = 16,
    parameter logic [2:0] LOAD_OP  = nrisc_pkg::LOAD_OP,
    parameter logic [2:0] STORE_OP = nrisc_pkg::STORE_OP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic       halt_req,
    input  logic [2:0] operation,
    input  logic [6:0] stage_done,
    output logic [6:0] stage_start,
    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] err_stage,
    output logic [7:0] retired
);

    import nrisc_pkg::*;

    seq_state_t state, state_n;
    logic       fresh;       // first cycle in the current state
    logic       by_step;     // current instruction was launched by step
    logic [2:0] op_q;        // opcode captured at MX done
    logic       in_stage;
    logic [2:0] cur_stage;
    logic       done_ok;     // accepted done for the current stage
    logic       wd_expired;
    logic       is_mem;
    logic       complete;
    logic       keep_running;

    assign in_stage     = is_stage_state(state);
    assign cur_stage    = stage_of(state);
    // A done that coincides with the strobe belongs to the previous use of
    // the stage, so only answers from the following cycle on are accepted.
    assign done_ok      = in_stage && !fresh && stage_done[cur_stage];
    assign is_mem       = (op_q == LOAD_OP) || (op_q == STORE_OP);
    assign keep_running = !by_step && run && !halt_req;

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_n != state),
        .enable  (in_stage),
        .expired (wd_expired)
    );

    // Next-state selection and strobe/busy decode; done takes priority over expiry.
    always_comb begin
        state_n     = state;
        complete    = 1'b0;
        stage_start = '0;
        busy        = in_stage;
        if (in_stage && fresh) begin
            stage_start = 7'd1 << cur_stage;
        end
        case (state)
            IDLE: begin
                if ((run && !halt_req) || step) state_n = S_PC;
            end
            S_PC, S_IM, S_MX, S_CT, S_RT: begin
                if (done_ok)         state_n = seq_state_t'(state + 4'd1);
                else if (wd_expired) state_n = ERROR;
            end
            S_AL: begin
                if (done_ok) begin
                    if (is_mem) begin
                        state_n = S_ME;
                    end else begin
                        complete = 1'b1;
                        state_n  = keep_running ? S_PC : IDLE;
                    end
                end else if (wd_expired) begin
                    state_n = ERROR;
                end
            end
            S_ME: begin
                if (done_ok) begin
                    complete = 1'b1;
                    state_n  = keep_running ? S_PC : IDLE;
                end else if (wd_expired) begin
                    state_n = ERROR;
                end
            end
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    // State register; fresh marks the strobe cycle of every newly entered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            fresh <= 1'b0;
        end else begin
            state <= state_n;
            fresh <= (state_n != state);
        end
    end

    // Instruction bookkeeping: launch source, opcode capture, retire count, error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            by_step     <= 1'b0;
            op_q        <= '0;
            retired     <= '0;
            timeout_err <= 1'b0;
            err_stage   <= '0;
        end else begin
            if ((state == IDLE) && (state_n == S_PC)) by_step <= step;
            if ((state == S_MX) && done_ok)           op_q    <= operation;
            if (complete)                             retired <= retired + 8'd1;
            if (in_stage && (state_n == ERROR)) begin
                timeout_err <= 1'b1;
                err_stage   <= cur_stage;
            end
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: stage responder, instruction-level reference
// model, a table of single-step instructions and directed corner sequences,
// followed by a randomized run/halt/step/opcode phase.
`timescale 1ns/1ps
module tb_stage_sequencer;

    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       halt_req = 1'b0;
    logic [2:0] operation = 3'd0;
    logic [6:0] stage_done = 7'd0;
    logic [6:0] stage_start;
    logic       busy;
    logic       timeout_err;
    logic [2:0] err_stage;
    logic [7:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: -1 idle, 0..6 stage being served, 7 error trap
    int         m_stage = -1;
    int         m_age = 0;        // cycles since this stage's strobe
    bit         m_by_step = 0;
    logic [2:0] m_op = 3'd0;
    int         m_ret = 0;
    bit         m_terr = 0;
    int         m_est = 0;

    // stage responder
    int pend = -1;
    int remain = 0;
    int resp_delay = 1;
    bit resp_rand = 0;
    bit resp_off = 0;
    int hold_stage = -1;

    stage_sequencer #(
        .TIMEOUT  (TO),
        .LOAD_OP  (3'b110),
        .STORE_OP (3'b111)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .operation   (operation),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_stage   (err_stage),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the instruction-level rules to the inputs about to be sampled.
    task automatic model_advance();
        bit acc;
        if (reset) begin
            m_stage = -1; m_age = 0; m_by_step = 0; m_op = 3'd0;
            m_ret = 0; m_terr = 0; m_est = 0; pend = -1;
            return;
        end
        if (m_stage == -1) begin
            if (step || (run && !halt_req)) begin
                m_stage = 0; m_age = 0; m_by_step = step;
            end
        end else if (m_stage <= 6) begin
            acc = (m_age > 0) && stage_done[m_stage];
            if (acc) begin
                if (m_stage == 2) m_op = operation;
                m_age = 0;
                if (m_stage < 5) m_stage++;
                else if (m_stage == 5 && (m_op == 3'b110 || m_op == 3'b111)) m_stage = 6;
                else begin
                    m_ret   = (m_ret + 1) % 256;
                    m_stage = (!m_by_step && run && !halt_req) ? 0 : -1;
                end
            end else if (m_age + 1 >= TO) begin
                m_terr = 1; m_est = m_stage; m_stage = 7;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic model_check();
        int es;
        es = (m_stage >= 0 && m_stage <= 6 && m_age == 0) ? (1 << m_stage) : 0;
        check("model stage_start", int'(stage_start), es);
        check("model busy", int'(busy), (m_stage >= 0 && m_stage <= 6) ? 1 : 0);
        check("model retired", int'(retired), m_ret);
        check("model timeout_err", int'(timeout_err), int'(m_terr));
        check("model err_stage", int'(err_stage), m_est);
    endtask

    // Answer each strobe with a done after the chosen number of cycles.
    task automatic responder();
        int idx;
        if (!resp_off) stage_done = 7'd0;
        idx = -1;
        for (int i = 0; i < 7; i++) if (stage_start[i]) idx = i;
        if (idx >= 0) begin
            pend   = idx;
            remain = resp_rand ? int'($urandom_range(5, 1)) : resp_delay;
        end else if (pend >= 0) begin
            remain--;
            if (remain <= 0 && !resp_off && pend != hold_stage) begin
                stage_done = 7'(1 << pend);
                pend = -1;
            end
        end
    endtask

    task automatic cycle();
        model_advance();
        @(posedge clock);
        #1;
        model_check();
        responder();
    endtask

    task automatic wait_strobe(input int idx, input string name);
        bit found;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (stage_start[idx]) found = 1;
        end
        check(name, int'(found), 1);
    endtask

    task automatic wait_idle(input string name);
        bit found;
        found = !busy;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle();
            if (!busy) found = 1;
        end
        check(name, int'(found), 1);
    endtask

    typedef struct {
        logic [2:0] op;
        int         dly;
        logic       halt;
        int         exp_cycles;
        logic       exp_me;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int r0, cyc, pos, comps, pcs, prev;
        logic me_seen;

        tbl[0] = '{3'b001, 1, 1'b0, 12, 1'b0};
        tbl[1] = '{3'b110, 1, 1'b0, 14, 1'b1};
        tbl[2] = '{3'b111, 2, 1'b0, 21, 1'b1};
        tbl[3] = '{3'b000, 3, 1'b0, 24, 1'b0};
        tbl[4] = '{3'b101, 2, 1'b0, 18, 1'b0};
        tbl[5] = '{3'b110, 4, 1'b0, 35, 1'b1};
        tbl[6] = '{3'b010, 1, 1'b1, 12, 1'b0};

        // reset state
        reset = 1'b1;
        cycle();
        cycle();
        check("reset stage_start", int'(stage_start), 0);
        check("reset busy", int'(busy), 0);
        check("reset retired", int'(retired), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        cycle();

        // single-step instructions from the table
        for (int t = 0; t < 7; t++) begin
            r0 = int'(retired);
            operation  = tbl[t].op;
            resp_delay = tbl[t].dly;
            halt_req   = tbl[t].halt;
            step = 1'b1;
            cycle();
            step = 1'b0;
            cyc = 0; pos = 0; me_seen = 1'b0;
            for (int k = 0; k < 100 && busy; k++) begin
                cyc++;
                if (stage_start != 7'd0) begin
                    check("table strobe order", int'(stage_start), 1 << pos);
                    pos++;
                    if (stage_start[6]) me_seen = 1'b1;
                end
                cycle();
            end
            check("table busy cycles", cyc, tbl[t].exp_cycles);
            check("table ME strobe", int'(me_seen), int'(tbl[t].exp_me));
            check("table retired", int'(retired), (r0 + 1) % 256);
            halt_req = 1'b0;
            cycle();
        end

        // load under run: opcode latched at MX, live input changed afterwards
        resp_delay = 1;
        r0 = int'(retired);
        run = 1'b1;
        operation = 3'b110;
        wait_strobe(3, "load CT strobe");
        operation = 3'b001;
        wait_strobe(6, "load ME strobe");
        check("load retired held before ME done", int'(retired), r0);
        cycle();
        cycle();
        check("load retired after ME done", int'(retired), (r0 + 1) % 256);
        check("load next PC strobe", int'(stage_start), 1);

        // halt requested during RT takes effect at the boundary
        wait_strobe(4, "halt RT strobe");
        halt_req = 1'b1;
        r0 = int'(retired);
        for (int k = 0; k < 50 && int'(retired) == r0; k++) cycle();
        check("halt retired", int'(retired), (r0 + 1) % 256);
        check("halt no PC strobe", int'(stage_start), 0);
        check("halt busy", int'(busy), 0);
        cycle();
        cycle();
        check("halt stays idle", int'(busy), 0);
        halt_req = 1'b0;
        cycle();
        check("resume PC strobe", int'(stage_start), 1);

        // done on the strobe cycle is ignored; reset during AL abandons the instruction
        run = 1'b0;
        wait_idle("drain to idle");
        resp_off = 1;
        step = 1'b1;
        cycle();
        step = 1'b0;
        check("early PC strobe", int'(stage_start), 1);
        stage_done = 7'b0000001;
        cycle();
        stage_done = 7'd0;
        check("early done no advance", int'(stage_start), 0);
        check("early done still busy", int'(busy), 1);
        cycle();
        cycle();
        check("early done no IM strobe", int'(stage_start), 0);
        stage_done = 7'b0000001;
        cycle();
        stage_done = 7'd0;
        check("late done IM strobe", int'(stage_start), 2);
        resp_off = 0;
        wait_strobe(5, "reset AL strobe");
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid reset stage_start", int'(stage_start), 0);
        check("mid reset busy", int'(busy), 0);
        check("mid reset retired", int'(retired), 0);
        cycle();
        check("no strobe after reset", int'(stage_start), 0);

        // watchdog: CT never answers
        run = 1'b1;
        operation = 3'b001;
        hold_stage = 3;
        wait_strobe(3, "timeout CT strobe");
        cyc = 1;
        for (int k = 0; k < 40 && !timeout_err; k++) begin
            cycle();
            if (!timeout_err) cyc++;
        end
        check("timeout cycles in CT", cyc, TO);
        check("timeout_err set", int'(timeout_err), 1);
        check("timeout err_stage", int'(err_stage), 3);
        check("timeout busy", int'(busy), 0);
        step = 1'b1;
        cycle();
        step = 1'b0;
        cycle();
        check("error no strobe", int'(stage_start), 0);
        check("error not busy", int'(busy), 0);
        hold_stage = -1;
        run = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset clears timeout_err", int'(timeout_err), 0);
        check("reset clears err_stage", int'(err_stage), 0);
        check("reset clears retired", int'(retired), 0);

        // 256 back-to-back ALU instructions: counter wraps, chain unbroken
        run = 1'b1;
        operation = 3'b011;
        resp_delay = 1;
        comps = 0; pcs = 0;
        prev = int'(retired);
        for (int k = 0; k < 256 * 12 + 100 && comps < 256; k++) begin
            cycle();
            if (stage_start[0]) pcs++;
            if (int'(retired) != prev) begin
                comps++;
                prev = int'(retired);
            end
        end
        check("wrap completions", comps, 256);
        check("wrap retired", int'(retired), 0);
        check("wrap PC strobes", pcs, 257);

        // randomized run/halt/step/opcode against the model
        resp_rand = 1;
        for (int k = 0; k < 2000; k++) begin
            run       = ($urandom_range(9, 0) != 0);
            halt_req  = ($urandom_range(7, 0) == 0);
            step      = ($urandom_range(15, 0) == 0);
            operation = 3'($urandom);
            cycle();
        end
        run = 1'b0;
        halt_req = 1'b0;
        step = 1'b0;
        wait_idle("random drain to idle");
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
